// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single memory port between instruction fetch and
// data load/store. Data has fixed priority over fetch; each access is
// bounded by a wait counter that aborts with bus_err after MAX_WAIT cycles.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_valid,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    localparam int unsigned    CNT_W     = 8;
    // Last busy cycle index before abort: MAX_WAIT busy cycles in total.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             grant_i;
    logic             grant_d;
    logic             ack_done;
    logic             timeout;
    logic             busy;

    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    // Stall toward the pipeline until the matching done pulse arrives.
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req  & ~d_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant/completion decode.
    always_comb begin
        state_d  = state_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        ack_done = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d = BUSY_D;
                    grant_d = 1'b1;
                end else if (if_req) begin
                    state_d = BUSY_I;
                    grant_i = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack on the final wait cycle still counts as success.
                if (mem_ack) begin
                    state_d  = DONE;
                    ack_done = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = DONE;
                    timeout = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching, wait counter, read capture and done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            bus_err  <= 1'b0;
            mem_req  <= (state_d == BUSY_I) || (state_d == BUSY_D);

            if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
            end else if (grant_i) begin
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                mem_be   <= 4'hF;
            end

            if (grant_i || grant_d) begin
                wait_cnt <= '0;
            end else if (busy && !mem_ack) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (ack_done || timeout) begin
                bus_err <= timeout;
                if (state_q == BUSY_I) begin
                    if_valid <= 1'b1;
                    if_rdata <= timeout ? 32'h0 : mem_rdata;
                end else begin
                    d_valid <= 1'b1;
                    if (!mem_we) begin
                        d_rdata <= timeout ? 32'h0 : mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16: bus-busy cycles without mem_ack before timeout abort (range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports if_req (in, 1, fetch request, level), if_addr (in, 32, fetch word address), if_rdata (out, 32, fetched word), if_valid (out, 1, fetch done pulse).
REQ-005 SHALL have ports d_req (in, 1, load/store request, level), d_we (in, 1, 1=store), d_addr (in, 32), d_wdata (in, 32), d_be (in, 4, byte enables), d_rdata (out, 32), d_valid (out, 1, data done pulse).
REQ-006 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_be (out, 4), mem_ack (in, 1), mem_rdata (in, 32): shared single memory port.
REQ-007 SHALL have outputs stall_if (1) and stall_mem (1): pipeline stall requests toward fetch and memory stages.
REQ-008 SHALL have output bus_err (1): one-cycle pulse on timeout abort.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DONE.
REQ-010 In IDLE, d_req=1 SHALL transition to BUSY_D; else if_req=1 to BUSY_I; else stay (fixed priority: data over fetch).
REQ-011 On IDLE->BUSY_x, SHALL latch requester address (and for data: we, wdata, be; fetch: we=0, be=4'hF) into registers driving mem_* outputs.
REQ-012 mem_req SHALL be 1 exactly while in BUSY_I/BUSY_D; mem_* fields SHALL stay constant throughout.
REQ-013 In BUSY_x with mem_ack=1, SHALL go to DONE; for reads, SHALL capture mem_rdata into if_rdata or d_rdata; stores leave d_rdata unchanged.
REQ-014 In DONE, SHALL assert exactly one of if_valid/d_valid (matching completed grant) for one cycle, then go to IDLE.
REQ-015 In DONE, SHALL ignore if_req/d_req (requesters drop req on seeing valid); no grant issued from DONE.
REQ-016 Latency: req sampled in IDLE at cycle N -> mem_req at N+1; mem_ack at cycle M>=N+1 -> valid at M+1; IDLE at M+2; min 3 cycles per access.
REQ-017 Wait counter (8-bit) SHALL clear on entering BUSY_x and increment each BUSY cycle with mem_ack=0.
REQ-018 When counter reaches MAX_WAIT with mem_ack=0, SHALL go to DONE, load 32'h0 into the requester's rdata (reads only), assert valid and bus_err together for one cycle.
REQ-019 mem_ack arriving in the same cycle the counter hits MAX_WAIT SHALL be treated as normal completion (no bus_err).
REQ-020 mem_ack while in IDLE or DONE SHALL be ignored.
REQ-021 stall_mem SHALL equal d_req & ~d_valid (combinational); stall_if SHALL equal if_req & ~if_valid.
REQ-022 Requests changing address while granted SHALL not affect the in-flight access.

Reset
REQ-023 On rst=1 at clock edge: state IDLE, counter 0, mem_req/mem_we/if_valid/d_valid/bus_err 0, mem_addr/mem_wdata/if_rdata/d_rdata 0, mem_be 0.
REQ-024 rst during BUSY_x SHALL drop mem_req next cycle; no valid pulse issued for the aborted access.

Verification
REQ-025 Fetch only: if_req=1, if_addr=0x100, mem_ack at 2nd BUSY cycle with rdata=0x00500093 -> mem_addr=0x100, mem_we=0, if_valid=1 with if_rdata=0x00500093 one cycle after ack.
REQ-026 Simultaneous if_req and d_req (load 0x2000) in IDLE -> data granted first; fetch granted only after d_valid and return to IDLE; stall_if high throughout.
REQ-027 Store d_addr=0x3004, d_wdata=0xDEADBEEF, d_be=4'b0011, ack immediate -> mem_we=1, mem_be=0011, d_valid after 1 cycle, d_rdata unchanged.
REQ-028 No ack, MAX_WAIT=16 -> mem_req held 16 cycles, then d_valid=1, bus_err=1, d_rdata=0, same cycle.
REQ-029 rst asserted mid BUSY_I -> mem_req=0 next cycle, if_valid never pulses, all outputs at reset values.
